// File: rtl/project_mux_pkg.sv
// Shared constants for the project multiplexer: register offsets, FSM encoding,
// CTRL bit positions and small helpers.
package project_mux_pkg;

  localparam logic [7:0] REG_ACTIVE = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_CTRL   = 8'h08;

  localparam int CTRL_RESTART = 0;
  localparam int CTRL_CLR_ERR = 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } mux_state_e;

  function automatic logic idx_legal(input logic [7:0] idx, input int num);
    return int'(idx) < num;
  endfunction

  function automatic logic [31:0] pack_status(input logic [7:0] cur, input logic [7:0] pend,
                                              input logic [1:0] st, input logic err);
    return {7'd0, err, 6'd0, st, pend, cur};
  endfunction

endpackage

// File: rtl/project_mux_wb_regs.sv
// Wishbone slave for the project multiplexer: window decode, single-cycle ack,
// registered readback and one-cycle write strobes toward the switch FSM.
module project_mux_wb_regs
  import project_mux_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [7:0]  st_current,
  input  logic [7:0]  st_pending,
  input  logic [1:0]  st_state,
  input  logic        st_err,
  output logic        active_wr,
  output logic [7:0]  active_data,
  output logic        ctrl_restart,
  output logic        ctrl_clr_err
);

  logic        in_win, req, wr;
  logic [7:0]  off;
  logic [31:0] rdata;
  logic        unused_bits;

  assign in_win = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off    = wbs_adr_i[7:0];
  // Holding off while ack is high gives exactly one ack per request.
  assign req    = wbs_cyc_i & wbs_stb_i & in_win & ~wbs_ack_o;
  assign wr     = req & wbs_we_i & wbs_sel_i[0];
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

  always_comb begin
    rdata = '0;
    case (off)
      REG_ACTIVE: rdata = {24'd0, st_pending};
      REG_STATUS: rdata = pack_status(st_current, st_pending, st_state, st_err);
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      active_wr    <= 1'b0;
      active_data  <= '0;
      ctrl_restart <= 1'b0;
      ctrl_clr_err <= 1'b0;
    end else begin
      wbs_ack_o    <= req;
      wbs_dat_o    <= (req && !wbs_we_i) ? rdata : '0;
      active_wr    <= wr && (off == REG_ACTIVE);
      active_data  <= wbs_dat_i[7:0];
      ctrl_restart <= wr && (off == REG_CTRL) && wbs_dat_i[CTRL_RESTART];
      ctrl_clr_err <= wr && (off == REG_CTRL) && wbs_dat_i[CTRL_CLR_ERR];
    end
  end

endmodule

// File: rtl/project_mux_ctrl.sv
// Project multiplexer: one GPIO bank shared by NUM_PROJECTS slots with a blanked
// drain gap and timed reset on switchover. Define IO_SYNC_EN to synchronise io_in.
module project_mux_ctrl
  import project_mux_pkg::*;
#(
  parameter int          NUM_PROJECTS = 8,
  parameter int          IO_WIDTH     = 38,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          SWITCH_GAP   = 4,
  parameter int          RESET_HOLD   = 8
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             wbs_stb_i,
  input  logic                             wbs_cyc_i,
  input  logic                             wbs_we_i,
  input  logic [3:0]                       wbs_sel_i,
  input  logic [31:0]                      wbs_adr_i,
  input  logic [31:0]                      wbs_dat_i,
  output logic                             wbs_ack_o,
  output logic [31:0]                      wbs_dat_o,
  input  logic [IO_WIDTH-1:0]              io_in,
  output logic [IO_WIDTH-1:0]              io_out,
  output logic [IO_WIDTH-1:0]              io_oeb,
  input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_out,
  input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_oeb,
  output logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_in,
  output logic [NUM_PROJECTS-1:0]          proj_rst,
  output logic [7:0]                       active_o
);

  localparam int CNT_MAX = (SWITCH_GAP > RESET_HOLD) ? SWITCH_GAP : RESET_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(SWITCH_GAP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(RESET_HOLD - 1);

  mux_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       current, pending, pend_nxt, active_data;
  logic             err, active_wr, ctrl_restart, ctrl_clr_err;
  logic             wr_legal, wr_illegal;
  logic [IO_WIDTH-1:0] io_gate;

  logic [NUM_PROJECTS-1:0][IO_WIDTH-1:0] slot_out, slot_oeb;
  assign slot_out = proj_io_out;
  assign slot_oeb = proj_io_oeb;

  project_mux_wb_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .st_current   (current),
    .st_pending   (pending),
    .st_state     (state),
    .st_err       (err),
    .active_wr    (active_wr),
    .active_data  (active_data),
    .ctrl_restart (ctrl_restart),
    .ctrl_clr_err (ctrl_clr_err)
  );

  assign wr_legal   = active_wr &&  idx_legal(active_data, NUM_PROJECTS);
  assign wr_illegal = active_wr && !idx_legal(active_data, NUM_PROJECTS);
  // Pending as it stands after this cycle's write, so a write landing on a
  // DRAIN/HOLD boundary is never lost.
  assign pend_nxt   = wr_legal ? active_data : pending;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= RUN;
      cnt     <= '0;
      current <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      if (wr_illegal)        err <= 1'b1;
      else if (ctrl_clr_err) err <= 1'b0;
      case (state)
        RUN: begin
          if (wr_legal && active_data != current) begin
            pending <= active_data;
            cnt     <= GAP_LD;
            state   <= DRAIN;
          end else if (ctrl_restart) begin
            pending <= current;
            cnt     <= GAP_LD;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          pending <= pend_nxt;
          if (cnt == '0) begin
            current <= pend_nxt;
            cnt     <= HOLD_LD;
            state   <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          pending <= pend_nxt;
          if (cnt == '0) begin
            if (pend_nxt != current) begin
              cnt   <= GAP_LD;
              state <= DRAIN;
            end else begin
              state <= RUN;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef IO_SYNC_EN
  logic [IO_WIDTH-1:0] sync_q1, sync_q2;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= io_in;
      sync_q2 <= sync_q1;
    end
  end
  assign io_gate = sync_q2;
`else
  assign io_gate = io_in;
`endif

  // Pads are blanked while in reset as well as outside RUN.
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    if (!wb_rst_i && state == RUN) begin
      for (int k = 0; k < NUM_PROJECTS; k++) begin
        if (current == 8'(k)) begin
          io_out = slot_out[k];
          io_oeb = slot_oeb[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_PROJECTS; k++) begin : g_slot
    logic sel;
    assign sel = (current == 8'(k));
    assign proj_io_in[k*IO_WIDTH +: IO_WIDTH] = (sel && state != DRAIN) ? io_gate : '0;
    assign proj_rst[k] = (state != RUN) || !sel;
  end

  assign active_o = current;

endmodule

// File: tb/tb_project_mux_ctrl.sv
// Scoreboarded bench for project_mux_ctrl against a switch-timeline reference model.
module tb_project_mux_ctrl;

  localparam int          NP       = 8;
  localparam int          IOW      = 38;
  localparam int          GAP      = 4;
  localparam int          HOLD_CYC = 8;
  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam logic [1:0]  P_RUN = 2'd0, P_DRAIN = 2'd1, P_HOLD = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b0, cyc = 1'b0, we_i = 1'b0;
  logic [3:0]  sel_i = '0;
  logic [31:0] adr_i = '0, dat_i = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [IOW-1:0]    io_in = '0, in_prev = '0;
  logic [IOW-1:0]    io_out, io_oeb;
  logic [NP*IOW-1:0] proj_io_out = '0, proj_io_oeb = '0, proj_io_in;
  logic [NP-1:0]     proj_rst;
  logic [7:0]        active_o;

  int checks = 0;
  int errors = 0;
  int unsigned ncyc = 0;

  typedef struct { logic is_rd; logic [31:0] data; string nm; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model: a switch is a timeline starting at m_t0.
  logic [7:0]  m_cur = '0, m_pend = '0;
  logic        m_err = 1'b0, m_busy = 1'b0;
  int unsigned m_t0 = 0;
  logic        wr_v = 1'b0, wr_sel0 = 1'b0;
  int unsigned wr_at = 0;
  logic [7:0]  wr_off = '0;
  logic [31:0] wr_dat = '0;

  project_mux_ctrl dut (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .wbs_stb_i (stb), .wbs_cyc_i (cyc), .wbs_we_i (we_i), .wbs_sel_i (sel_i),
    .wbs_adr_i (adr_i), .wbs_dat_i (dat_i), .wbs_ack_o (ack), .wbs_dat_o (dat_o),
    .io_in (io_in), .io_out (io_out), .io_oeb (io_oeb),
    .proj_io_out (proj_io_out), .proj_io_oeb (proj_io_oeb), .proj_io_in (proj_io_in),
    .proj_rst (proj_rst), .active_o (active_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  function automatic logic [1:0] m_phase();
    if (!m_busy) return P_RUN;
    return ((ncyc - m_t0) < GAP) ? P_DRAIN : P_HOLD;
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] off);
    case (off)
      8'h00:   return {24'h0, m_pend};
      8'h04:   return {7'h0, m_err, 6'h0, m_phase(), m_pend, m_cur};
      default: return 32'h0;
    endcase
  endfunction

  task automatic apply_write();
    logic [7:0] v;
    if (!wr_sel0) return;
    if (wr_off == 8'h00) begin
      v = wr_dat[7:0];
      if (v >= NP) m_err = 1'b1;
      else if (m_busy) m_pend = v;
      else if (v != m_cur) begin m_pend = v; m_busy = 1'b1; m_t0 = ncyc; end
    end else if (wr_off == 8'h08) begin
      if (wr_dat[0] && !m_busy) begin m_pend = m_cur; m_busy = 1'b1; m_t0 = ncyc; end
      if (wr_dat[1]) m_err = 1'b0;
    end
  endtask

  task automatic check_pads();
    logic [IOW-1:0]    eo, eoe, in_eff;
    logic [NP-1:0]     er;
    logic [NP*IOW-1:0] ep;
    logic [1:0]        ph;
    int c;
`ifdef IO_SYNC_EN
    in_eff = in_prev;
`else
    in_eff = io_in;
`endif
    eo = '0; eoe = '1; er = '1; ep = '0;
    if (rst) begin
      er[0] = 1'b0;
      chk("rst_active", active_o, 0);
    end else begin
      ph = m_phase();
      c  = int'(m_cur);
      if (ph == P_RUN) begin
        eo = proj_io_out[c*IOW +: IOW];
        eoe = proj_io_oeb[c*IOW +: IOW];
        er[c] = 1'b0;
      end
      if (ph != P_DRAIN) ep[c*IOW +: IOW] = in_eff;
      chk("active_o", active_o, m_cur);
      chk("proj_io_in", proj_io_in, ep);
    end
    chk("io_out", io_out, eo);
    chk("io_oeb", io_oeb, eoe);
    chk("proj_rst", proj_rst, er);
  endtask

  // Model advance, pad checks and fresh random pad/project inputs each cycle.
  always @(negedge clk) begin
    logic [63:0] r;
    if (rst) begin
      m_cur = '0; m_pend = '0; m_err = 1'b0; m_busy = 1'b0; wr_v = 1'b0;
    end else begin
      if (wr_v && wr_at == ncyc) begin apply_write(); wr_v = 1'b0; end
      if (m_busy) begin
        if ((ncyc - m_t0) == GAP) m_cur = m_pend;
        else if ((ncyc - m_t0) == GAP + HOLD_CYC) begin
          if (m_pend != m_cur) m_t0 = ncyc;
          else m_busy = 1'b0;
        end
      end
    end
    check_pads();
    in_prev = io_in;
    r = {$urandom, $urandom}; io_in = r[IOW-1:0];
    for (int k = 0; k < NP; k++) begin
      r = {$urandom, $urandom}; proj_io_out[k*IOW +: IOW] = r[IOW-1:0];
      r = {$urandom, $urandom}; proj_io_oeb[k*IOW +: IOW] = r[IOW-1:0];
    end
    proj_io_out[3*IOW +: IOW] = 38'h15555;
    proj_io_oeb[3*IOW +: IOW] = '0;
  end

  // Response monitor: every ack consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && ack) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack got 1 exp 0");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_rd) chk(mon_e.nm, dat_o, mon_e.data);
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input string nm);
    logic in_win;
    bit   got;
    exp_t e;
    @(negedge clk); #1;
    in_win = (adr[31:8] == BASE[31:8]);
    if (in_win) begin
      e.is_rd = !we; e.data = we ? 32'h0 : exp_read(adr[7:0]); e.nm = nm;
      sb.push_back(e);
      if (we) begin
        wr_v = 1'b1; wr_at = ncyc + 2; wr_off = adr[7:0]; wr_dat = dat; wr_sel0 = sel[0];
      end
    end
    cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; break; end
    end
    cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
    checks++;
    if (got != in_win) begin
      errors++;
      $display("FAIL %s_ack got %0d exp %0d", nm, got, in_win);
      if (in_win) void'(sb.pop_back());
    end
  endtask

  initial begin
    int blank;
    logic [3:0] s;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, "reset_status");

    // Switch to slot 3: 12 blanked cycles, then slot 3 drives.
    wb_xfer(1'b1, BASE + 32'h00, 32'd3, 4'hF, "act3");
    blank = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (io_oeb == '1 && io_out == '0) blank++;
    end
    chk("blank_cycles", blank, 12);
    @(negedge clk);
    chk("sw_io_out", io_out, 38'h15555);
    chk("sw_rst", proj_rst, 8'hF7);

    // Illegal index sets sticky err; CTRL bit1 clears it.
    wb_xfer(1'b1, BASE + 32'h00, 32'd9, 4'hF, "act9");
    wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, "err_status");
    wb_xfer(1'b1, BASE + 32'h08, 32'd2, 4'hF, "clr_err");
    wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, "clr_status");

    // Retarget during DRAIN.
    wb_xfer(1'b1, BASE + 32'h00, 32'd2, 4'hF, "act2");
    wb_xfer(1'b1, BASE + 32'h00, 32'd5, 4'hF, "act5");
    wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, "retarget_status");
    repeat (30) @(negedge clk);
    wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, "landed_status");
    chk("landed_active", active_o, 8'd5);

    // sel[0]=0 write is ignored; restart re-runs the current slot.
    wb_xfer(1'b1, BASE + 32'h00, 32'd1, 4'hE, "nosel");
    wb_xfer(1'b1, BASE + 32'h08, 32'd1, 4'hF, "restart");
    repeat (6) @(negedge clk);
    wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, "restart_status");
    wb_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, "active_rd");
    repeat (16) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      s = ($urandom_range(0, 4) == 0) ? 4'hE : 4'hF;
      case ($urandom_range(0, 3))
        0: wb_xfer(1'b1, BASE + 32'h00, 32'($urandom_range(0, 11)), s, "rnd_act");
        1: wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, "rnd_status");
        2: wb_xfer(1'b1, BASE + 32'h08, 32'($urandom_range(0, 3)), s, "rnd_ctrl");
        default: repeat ($urandom_range(0, 15)) @(negedge clk);
      endcase
    end
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of HOLD.
    wb_xfer(1'b1, BASE + 32'h00, 32'd6, 4'hF, "act6");
    repeat (30) @(negedge clk);
    wb_xfer(1'b1, BASE + 32'h00, 32'd1, 4'hF, "act1");
    repeat (8) @(negedge clk);
    chk("pre_rst_hold", proj_rst, 8'hFF);
    #3 rst = 1'b1;
    #1;
    chk("async_io_out", io_out, 0);
    chk("async_io_oeb", io_oeb, {IOW{1'b1}});
    chk("async_proj_rst", proj_rst, 8'hFE);
    chk("async_active", active_o, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, "post_rst_status");

    wb_xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF, "hole_rd");
    wb_xfer(1'b0, 32'h3000_0200, 32'h0, 4'hF, "outside_rd");
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout got running exp finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
